// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter between instruction fetch and load/store.
// Fixed priority to MEM; each access is split into per-byte RAM cycles.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [2:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [2:0]        step;
  logic [2:0]        nstep;
  logic              owner_mem;
  logic [ADDR_W-1:0] base;
  logic [2:0]        len;
  logic [2:0]        mlen_n;
  logic              wr;
  logic [31:0]       wdata;
  logic [31:0]       result;
  logic [31:0]       res_nx;
  logic [7:0]        wbyte;
  logic              fin;

  assign nstep = step + 3'd1;
  assign mlen_n = (mem_len == 3'd0 || mem_len > 3'd4) ? 3'd4 : mem_len;
  assign fin = wr ? (nstep == len) : (step == len);

  // RAM data lags the address by one cycle, so step s fills byte s-1
  always_comb begin
    res_nx = result;
    case (step)
      3'd1: res_nx[7:0]   = ram_din;
      3'd2: res_nx[15:8]  = ram_din;
      3'd3: res_nx[23:16] = ram_din;
      3'd4: res_nx[31:24] = ram_din;
      default: ;
    endcase
  end

  always_comb begin
    wbyte = wdata[7:0];
    case (nstep[1:0])
      2'd1: wbyte = wdata[15:8];
      2'd2: wbyte = wdata[23:16];
      2'd3: wbyte = wdata[31:24];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      step      <= 3'd0;
      owner_mem <= 1'b0;
      base      <= '0;
      len       <= 3'd0;
      wr        <= 1'b0;
      wdata     <= 32'd0;
      result    <= 32'd0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_data   <= 32'd0;
      mem_rdata <= 32'd0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= 8'd0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_req) begin
            owner_mem <= 1'b1;
            base      <= mem_addr;
            len       <= mlen_n;
            wr        <= mem_write;
            wdata     <= mem_wdata;
            step      <= 3'd0;
            result    <= 32'd0;
            state     <= BUSY;
            ram_addr  <= mem_addr;
            ram_wr    <= mem_write;
            ram_dout  <= mem_wdata[7:0];
          end else if (if_req) begin
            owner_mem <= 1'b0;
            base      <= if_addr;
            len       <= 3'd4;
            wr        <= 1'b0;
            wdata     <= 32'd0;
            step      <= 3'd0;
            result    <= 32'd0;
            state     <= BUSY;
            ram_addr  <= if_addr;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'd0;
          end
        end
        BUSY: begin
          step   <= nstep;
          result <= res_nx;
          if (nstep < len) begin
            ram_addr <= base + ADDR_W'(nstep);
            ram_wr   <= wr;
            ram_dout <= wbyte;
          end else begin
            ram_addr <= '0;
            ram_wr   <= 1'b0;
            ram_dout <= 8'd0;
          end
          if (fin) begin
            state <= DONE;
            if (owner_mem) begin
              mem_done <= 1'b1;
              if (!wr) mem_rdata <= res_nx;
            end else begin
              if_done <= 1'b1;
              if_data <= res_nx;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model.
// Table of single accesses plus arbitration and reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [2:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  int asserts = 0;
  int fails = 0;

  logic [7:0]  ram [0:4095];
  logic        pl_we = 1'b0;
  logic [11:0] pl_a = '0;
  logic [7:0]  pl_d = '0;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .ram_addr(ram_addr),
    .ram_wr(ram_wr), .ram_dout(ram_dout),
    .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we) ram[pl_a] <= pl_d;
    else if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
    ram_din <= ram[ram_addr[11:0]];
  end

  typedef struct {
    logic        is_if;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    int          nb;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_we = 1'b1;
    pl_a = a;
    pl_d = d;
    @(posedge clk);
    #1;
    pl_we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit seen;
    logic own;
    logic other;
    logic [31:0] got;
    seen = 0;
    if (v.is_if) begin
      if_req = 1'b1;
      if_addr = v.addr;
    end else begin
      mem_req = 1'b1;
      mem_write = v.wr;
      mem_addr = v.addr;
      mem_len = v.len;
      mem_wdata = v.wdata;
    end
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (k <= v.nb) begin
        check($sformatf("v%0d ram_addr k%0d", idx, k), ram_addr,
              v.addr + 32'(k - 1));
        check($sformatf("v%0d ram_wr k%0d", idx, k), {31'd0, ram_wr},
              {31'd0, v.wr});
        if (v.wr)
          check($sformatf("v%0d ram_dout k%0d", idx, k), {24'd0, ram_dout},
                (v.wdata >> (8 * (k - 1))) & 32'hFF);
      end else begin
        check($sformatf("v%0d idle ram_wr k%0d", idx, k), {31'd0, ram_wr},
              32'd0);
        check($sformatf("v%0d idle ram_addr k%0d", idx, k), ram_addr, 32'd0);
      end
      own = v.is_if ? if_done : mem_done;
      other = v.is_if ? mem_done : if_done;
      check($sformatf("v%0d other_done k%0d", idx, k), {31'd0, other}, 32'd0);
      if (own) begin
        seen = 1;
        check($sformatf("v%0d latency", idx), 32'(k), 32'(v.exp_lat));
        if (!v.wr) begin
          got = v.is_if ? if_data : mem_rdata;
          check($sformatf("v%0d data", idx), got, v.exp_data);
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        mem_write = 1'b0;
      end
    end
    if (!seen) check($sformatf("v%0d timeout", idx), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    own = v.is_if ? if_done : mem_done;
    check($sformatf("v%0d done pulse width", idx), {31'd0, own}, 32'd0);
  endtask

  initial begin
    int mcyc;
    int icyc;
    bit time_out;
    reset = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    mem_req = 1'b0;
    mem_write = 1'b0;
    mem_addr = '0;
    mem_len = '0;
    mem_wdata = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 3'd4, 32'h0, 4, 32'h0010_0513, 6};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0020, 3'd2, 32'hAABB_CCDD, 2, 32'h0, 3};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0040, 3'd1, 32'h0, 1, 32'h0000_0080, 3};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 3'd4, 32'h0, 4, 32'h4433_2211, 6};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0100, 3'd0, 32'h0, 4, 32'h0010_0513, 6};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0041, 3'd2, 32'h0, 2, 32'h0000_7FFE, 4};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0030, 3'd4, 32'h1122_3344, 4, 32'h0, 5};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0030, 3'd5, 32'h0, 4, 32'h1122_3344, 6};

    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst if_done", {31'd0, if_done}, 32'd0);
    check("rst mem_done", {31'd0, mem_done}, 32'd0);
    check("rst if_data", if_data, 32'd0);
    check("rst mem_rdata", mem_rdata, 32'd0);
    check("rst ram_addr", ram_addr, 32'd0);
    check("rst ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst ram_dout", {24'd0, ram_dout}, 32'd0);
    reset = 1'b0;

    preload(12'h100, 8'h13);
    preload(12'h101, 8'h05);
    preload(12'h102, 8'h10);
    preload(12'h103, 8'h00);
    preload(12'h022, 8'h5A);
    preload(12'h023, 8'h5A);
    preload(12'h040, 8'h80);
    preload(12'h041, 8'hFE);
    preload(12'h042, 8'h7F);
    preload(12'hFFE, 8'h11);
    preload(12'hFFF, 8'h22);
    preload(12'h000, 8'h33);
    preload(12'h001, 8'h44);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    check("store byte 0x20", {24'd0, ram[12'h020]}, 32'hDD);
    check("store byte 0x21", {24'd0, ram[12'h021]}, 32'hCC);
    check("untouched 0x22", {24'd0, ram[12'h022]}, 32'h5A);
    check("untouched 0x23", {24'd0, ram[12'h023]}, 32'h5A);

    // both requests in one IDLE cycle
    mcyc = 0;
    icyc = 0;
    mem_req = 1'b1;
    mem_write = 1'b0;
    mem_addr = 32'h30;
    mem_len = 3'd4;
    if_req = 1'b1;
    if_addr = 32'h100;
    for (int k = 1; k <= 30 && (mcyc == 0 || icyc == 0); k++) begin
      @(posedge clk);
      #1;
      check($sformatf("sim both_done k%0d", k),
            {31'd0, mem_done & if_done}, 32'd0);
      if (mem_done) begin
        mcyc = k;
        check("sim mem_rdata", mem_rdata, 32'h1122_3344);
        mem_req = 1'b0;
      end
      if (if_done) begin
        icyc = k;
        check("sim if_data", if_data, 32'h0010_0513);
        if_req = 1'b0;
      end
    end
    check("sim mem cycle", 32'(mcyc), 32'd6);
    check("sim if cycle", 32'(icyc), 32'd13);
    @(posedge clk);
    #1;

    // reset at step 2 of a 4-byte store
    mem_req = 1'b1;
    mem_write = 1'b1;
    mem_addr = 32'h50;
    mem_len = 3'd4;
    mem_wdata = 32'hDEAD_BEEF;
    time_out = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) begin
        check("rst mid step2 addr", ram_addr, 32'h52);
        check("rst mid step2 wr", {31'd0, ram_wr}, 32'd1);
      end
    end
    reset = 1'b1;
    mem_req = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort ram_wr", {31'd0, ram_wr}, 32'd0);
    check("abort ram_addr", ram_addr, 32'd0);
    check("abort ram_dout", {24'd0, ram_dout}, 32'd0);
    check("abort if_data", if_data, 32'd0);
    check("abort mem_rdata", mem_rdata, 32'd0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("abort no done k%0d", k),
            {30'd0, mem_done, if_done}, 32'd0);
      @(posedge clk);
      #1;
    end
    if (time_out) check("abort timeout", 32'd0, 32'd1);
    run_vec(vecs[0], 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single byte-wide synchronous RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Serialises each 1–4 byte access into per-byte RAM cycles, then returns one done pulse with the assembled little-endian word.
- Sits between the IF/MEM pipeline stages and the external RAM. Stall logic holds a stage while its request is pending.

Parameters:
ADDR_W, 32, width of all address ports

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  IF fetch request (always a 4-byte read); held until if_done
if_addr  in  ADDR_W  IF byte address
if_done  out  1  one-cycle pulse when the fetch completes
if_data  out  32  fetched word; valid while if_done=1
mem_req  in  1  MEM access request; held until mem_done
mem_write  in  1  1=store, 0=load
mem_addr  in  ADDR_W  MEM byte address
mem_len  in  3  byte count 1, 2 or 4; 0 or greater than 4 is treated as 4
mem_wdata  in  32  store data; byte k is mem_wdata[8k+7:8k]
mem_done  out  1  one-cycle pulse when the MEM access completes
mem_rdata  out  32  load data, zero-extended; valid while mem_done=1
ram_addr  out  ADDR_W  RAM byte address
ram_wr  out  1  RAM write strobe
ram_dout  out  8  RAM write data
ram_din  in  8  RAM read data; byte for the address presented in cycle t arrives in cycle t+1

Behaviour:
- All outputs are registered.
- On reset: state=IDLE, step=0. All outputs are 0: if_done, mem_done, if_data, mem_rdata, ram_addr, ram_wr, ram_dout.
- FSM states: IDLE, BUSY, DONE.
- IDLE, grant:
  - mem_req wins over if_req (fixed priority).
  - On grant, latch owner, base address, len, write flag and wdata; set step=0; go to BUSY.
  - IF grants latch len=4 and write=0.
  - With no request, stay in IDLE.
- BUSY, step s:
  - If s<len: drive ram_addr=base+s (mod 2^ADDR_W, wraps), ram_wr=write, ram_dout=wdata byte s.
  - If s>=len: ram_wr=0, ram_addr=0.
  - Read: at step s>=1, capture ram_din into result byte s-1. After capturing byte len-1 (step=len), go to DONE.
  - Write: after step len-1, go to DONE.
- DONE: pulse the owner's done for exactly one cycle with its data register valid, then return to IDLE. Arbitration resumes in the IDLE cycle.
- Latency, with grant in cycle T:
  - Read of len bytes: done at cycle T+len+2 (4-byte fetch: T+6).
  - Write: done at cycle T+len+1.
- Requester rules:
  - Inputs are sampled only at grant. Changes to addr, wdata or req during BUSY are ignored, and the access always completes.
  - A requester must deassert req in the cycle after its done. If req is still high in IDLE, it is re-granted as a new access.
- Result data:
  - Reads with len<4 zero-fill the upper bytes. Sign extension is done downstream.
  - mem_rdata and if_data hold their value after done until the next completion of the same port.
- Non-owner done stays 0.
- If both requests arrive in the same IDLE cycle, MEM is served first and IF is granted in the IDLE cycle after MEM's DONE.
- Reset mid-operation: the access is aborted, no done is issued, ram_wr drops in the next cycle and state returns to IDLE.
- Outside BUSY steps 0..len-1, ram_wr is always 0.

Test Plan:
- IF fetch: if_req=1, if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_addr 0x100..0x103 on consecutive cycles; if_done pulses once at T+6 with if_data=0x00100513.
- MEM store: mem_write=1, len=2, addr=0x20, wdata=0xAABBCCDD -> writes 0xDD@0x20 then 0xCC@0x21 with ram_wr=1; mem_done at T+3; memory bytes 0x22/0x23 untouched.
- MEM byte load: len=1, byte 0x80 at 0x40 -> mem_rdata=0x00000080 at T+3.
- Simultaneous requests: if_req and mem_req (4-byte load) asserted in the same cycle -> MEM completes first; IF is granted after MEM's DONE; if_done never coincides with mem_done.
- Wrap: 4-byte load at addr=0xFFFFFFFE -> ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset mid-op: reset asserted at step 2 of a 4-byte store -> no done pulse, ram_wr=0 next cycle, outputs 0; a subsequent if_req is served normally.
